// File: rtl/axi_sram_responder_if.sv
// Bundle of the SRAM-like request port and the single-beat AXI4 master port.
// The slave modport is the responder's view; master is the surrounding system.
interface axi_sram_responder_if #(
    parameter int ID_WIDTH = 4
);
    logic                req_valid;
    logic [31:0]         req_addr;
    logic                req_we;
    logic [1:0]          req_size;
    logic [3:0]          req_wstrb;
    logic [31:0]         req_wdata;
    logic                req_addr_ok;
    logic                req_data_ok;
    logic [31:0]         req_rdata;
    logic                resp_err;

    logic [ID_WIDTH-1:0] m_arid;
    logic [31:0]         m_araddr;
    logic [7:0]          m_arlen;
    logic [2:0]          m_arsize;
    logic [1:0]          m_arburst;
    logic                m_arvalid;
    logic                m_arready;

    logic [ID_WIDTH-1:0] m_rid;
    logic [31:0]         m_rdata;
    logic [1:0]          m_rresp;
    logic                m_rlast;
    logic                m_rvalid;
    logic                m_rready;

    logic [ID_WIDTH-1:0] m_awid;
    logic [31:0]         m_awaddr;
    logic [7:0]          m_awlen;
    logic [2:0]          m_awsize;
    logic [1:0]          m_awburst;
    logic                m_awvalid;
    logic                m_awready;

    logic [31:0]         m_wdata;
    logic [3:0]          m_wstrb;
    logic                m_wlast;
    logic                m_wvalid;
    logic                m_wready;

    logic [ID_WIDTH-1:0] m_bid;
    logic [1:0]          m_bresp;
    logic                m_bvalid;
    logic                m_bready;

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_wstrb, req_wdata,
        output req_addr_ok, req_data_ok, req_rdata, resp_err,
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        input  m_arready,
        input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready,
        output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bid, m_bresp, m_bvalid,
        output m_bready
    );

    modport master (
        output req_valid, req_addr, req_we, req_size, req_wstrb, req_wdata,
        input  req_addr_ok, req_data_ok, req_rdata, resp_err,
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        output m_arready,
        output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready,
        input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready,
        output m_bid, m_bresp, m_bvalid,
        input  m_bready
    );
endinterface

// File: rtl/axi_sram_responder.sv
// Turns one SRAM-like request at a time into a single-beat AXI4 read or write.
// Optional macro WR_EARLY_ACK_EN: acknowledge writes once AW and W are accepted.
module axi_sram_responder #(
    parameter int ID_WIDTH = 4,
    parameter int RD_ID    = 0,
    parameter int WR_ID    = 1
) (
    input logic                  clk,
    input logic                  reset,
    axi_sram_responder_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

    state_t      state, next_state;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic        aw_done, w_done, ack_pending, err_q;
    logic        arvalid, rready, awvalid, wvalid, bready, addr_ok, data_ok;
    logic        accept, aw_fire, w_fire, unused_inputs;

    assign accept  = bus.req_valid && addr_ok;
    assign aw_fire = awvalid && bus.m_awready;
    assign w_fire  = wvalid && bus.m_wready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        addr_ok    = 1'b0;
        data_ok    = ack_pending;
        case (state)
            IDLE: begin
                addr_ok = 1'b1;
                if (bus.req_valid) next_state = bus.req_we ? WR_REQ : RD_ADDR;
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (bus.m_arready) next_state = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (bus.m_rvalid && bus.m_rlast) next_state = DONE;
            end
            WR_REQ: begin
                // AW and W retire independently; leave only when both are done
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || aw_fire) && (w_done || w_fire)) next_state = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
`ifdef WR_EARLY_ACK_EN
                if (bus.m_bvalid) next_state = IDLE;
`else
                if (bus.m_bvalid) next_state = DONE;
`endif
            end
            DONE: begin
                data_ok    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            wstrb_q     <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            ack_pending <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            ack_pending <= 1'b0;
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                size_q  <= bus.req_size;
                wstrb_q <= bus.req_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
            if (state == RD_DATA && bus.m_rvalid && bus.m_rlast) begin
                rdata_q <= bus.m_rdata;
                err_q   <= (bus.m_rresp != 2'b00);
            end
`ifdef WR_EARLY_ACK_EN
            // Early acknowledge always reports OKAY; the real BRESP is discarded
            if (state == WR_REQ && next_state == WR_RESP) begin
                ack_pending <= 1'b1;
                err_q       <= 1'b0;
            end
`else
            if (state == WR_RESP && bus.m_bvalid) err_q <= (bus.m_bresp != 2'b00);
`endif
        end
    end

    assign bus.req_addr_ok = addr_ok;
    assign bus.req_data_ok = data_ok;
    assign bus.req_rdata   = rdata_q;
    assign bus.resp_err    = err_q;

    assign bus.m_arid    = ID_WIDTH'(RD_ID);
    assign bus.m_araddr  = addr_q;
    assign bus.m_arlen   = 8'd0;
    assign bus.m_arsize  = {1'b0, size_q};
    assign bus.m_arburst = 2'b01;
    assign bus.m_arvalid = arvalid;
    assign bus.m_rready  = rready;

    assign bus.m_awid    = ID_WIDTH'(WR_ID);
    assign bus.m_awaddr  = addr_q;
    assign bus.m_awlen   = 8'd0;
    assign bus.m_awsize  = {1'b0, size_q};
    assign bus.m_awburst = 2'b01;
    assign bus.m_awvalid = awvalid;
    assign bus.m_wdata   = wdata_q;
    assign bus.m_wstrb   = wstrb_q;
    assign bus.m_wlast   = 1'b1;
    assign bus.m_wvalid  = wvalid;
    assign bus.m_bready  = bready;

    // Only one transaction is ever in flight, so returned IDs carry no information
    assign unused_inputs = ^{bus.m_rid, bus.m_bid, bus.m_bresp};
endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: a vector table of single transactions with
// a delay-configurable AXI slave model, plus back-to-back and mid-transaction reset sequences.
module tb_axi_sram_responder;
    localparam int ID_WIDTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_sram_responder_if #(.ID_WIDTH(ID_WIDTH)) bus ();

    axi_sram_responder #(.ID_WIDTH(ID_WIDTH), .RD_ID(0), .WR_ID(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [2:0]  axsize;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          a_delay;
        int          w_delay;
        int          resp_delay;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          exp_lat;
        int          exp_idle;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearSlave();
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rlast   = 1'b0;
        bus.m_rdata   = '0;
        bus.m_rresp   = '0;
        bus.m_rid     = '0;
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.m_bvalid  = 1'b0;
        bus.m_bresp   = '0;
        bus.m_bid     = '0;
    endtask

    // One request through an AXI slave whose ready/response delays come from the vector
    task automatic applyStimulus(input vec_t v, input int idx);
        int   ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
        int   pulses = 0, lat = -1, idle = -1;
        logic ar_fired = 0, aw_fired = 0, w_fired = 0, r_fired = 0, b_fired = 0;
        logic nxt_ar, nxt_aw, nxt_w;
        logic [31:0] got_rdata = '0;
        logic        got_err = 1'b0;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        checkOutput({tag, " addr_ok before accept"}, 32'(bus.req_addr_ok), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = v.addr;
        bus.req_we    = v.we;
        bus.req_size  = v.size;
        bus.req_wstrb = v.wstrb;
        bus.req_wdata = v.wdata;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.req_valid = 1'b0;
                bus.req_addr  = ~v.addr;
                bus.req_wdata = ~v.wdata;
                bus.req_wstrb = ~v.wstrb;
                bus.req_size  = 2'd3;
            end
            if (bus.req_addr_ok) begin
                idle = k;
                break;
            end
            if (bus.req_data_ok) begin
                pulses++;
                if (lat < 0) begin
                    lat       = k;
                    got_rdata = bus.req_rdata;
                    got_err   = bus.resp_err;
                end
            end
            nxt_ar = 1'b0;
            if (bus.m_arvalid) begin
                ar_cnt++;
                if (ar_cnt == 1) begin
                    checkOutput({tag, " araddr"}, bus.m_araddr, v.addr);
                    checkOutput({tag, " arsize"}, 32'(bus.m_arsize), 32'(v.axsize));
                    checkOutput({tag, " arlen/arburst"}, {22'd0, bus.m_arlen, bus.m_arburst}, 32'h1);
                end
                bus.m_arready = (ar_cnt > v.a_delay);
                nxt_ar = bus.m_arready;
            end else bus.m_arready = 1'b0;
            if (ar_fired && !r_fired) begin
                r_cnt++;
                if (r_cnt > v.resp_delay) begin
                    bus.m_rvalid = 1'b1;
                    bus.m_rlast  = 1'b1;
                    bus.m_rdata  = v.rdata;
                    bus.m_rresp  = v.resp;
                    if (bus.m_rready) r_fired = 1'b1;
                end
            end else begin
                bus.m_rvalid = 1'b0;
                bus.m_rlast  = 1'b0;
            end
            ar_fired |= nxt_ar;
            nxt_aw = 1'b0;
            if (bus.m_awvalid) begin
                aw_cnt++;
                if (aw_cnt == 1) begin
                    checkOutput({tag, " awaddr"}, bus.m_awaddr, v.addr);
                    checkOutput({tag, " awsize"}, 32'(bus.m_awsize), 32'(v.axsize));
                    checkOutput({tag, " awlen/awburst"}, {22'd0, bus.m_awlen, bus.m_awburst}, 32'h1);
                end
                bus.m_awready = (aw_cnt > v.a_delay);
                nxt_aw = bus.m_awready;
            end else bus.m_awready = 1'b0;
            nxt_w = 1'b0;
            if (bus.m_wvalid) begin
                w_cnt++;
                if (w_cnt == 1) begin
                    checkOutput({tag, " wdata"}, bus.m_wdata, v.wdata);
                    checkOutput({tag, " wstrb/wlast"}, {27'd0, bus.m_wstrb, bus.m_wlast}, {27'd0, v.wstrb, 1'b1});
                end
                bus.m_wready = (w_cnt > v.w_delay);
                nxt_w = bus.m_wready;
            end else bus.m_wready = 1'b0;
            if (aw_fired && w_fired && !b_fired) begin
                b_cnt++;
                if (b_cnt > v.resp_delay) begin
                    bus.m_bvalid = 1'b1;
                    bus.m_bresp  = v.resp;
                    if (bus.m_bready) b_fired = 1'b1;
                end
            end else bus.m_bvalid = 1'b0;
            aw_fired |= nxt_aw;
            w_fired  |= nxt_w;
        end
        clearSlave();
        checkOutput({tag, " data_ok latency"}, 32'(lat), 32'(v.exp_lat));
        checkOutput({tag, " addr_ok return cycle"}, 32'(idle), 32'(v.exp_idle));
        checkOutput({tag, " data_ok pulses"}, 32'(pulses), 32'd1);
        checkOutput({tag, " req_rdata"}, got_rdata, v.exp_rdata);
        checkOutput({tag, " resp_err"}, 32'(got_err), 32'(v.exp_err));
        if (v.we) begin
            checkOutput({tag, " awvalid cycles"}, 32'(aw_cnt), 32'(v.a_delay + 1));
            checkOutput({tag, " wvalid cycles"}, 32'(w_cnt), 32'(v.w_delay + 1));
            checkOutput({tag, " B handshake/no AR"}, {30'd0, b_fired, ar_cnt == 0}, 32'h3);
        end else begin
            checkOutput({tag, " arvalid cycles"}, 32'(ar_cnt), 32'(v.a_delay + 1));
            checkOutput({tag, " R handshake/no AW"}, {30'd0, r_fired, aw_cnt == 0}, 32'h3);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] exp_addr_ok, exp_data_ok;

        //            we addr          sz axs wstrb    wdata         ad wd rd  rdata         resp  lat idle exp_rdata     err
        vecs[0] = '{1'b0, 32'h1c000004, 2'd2, 3'd2, 4'b0000, 32'h0,        2, 0, 3, 32'hDEADBEEF, 2'b00, 8, 9, 32'hDEADBEEF, 1'b0};
`ifdef WR_EARLY_ACK_EN
        vecs[1] = '{1'b1, 32'h1c000002, 2'd0, 3'd0, 4'b0100, 32'h5A5A5A5A, 0, 1, 0, 32'h0,        2'b00, 3, 4, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h1c000008, 2'd2, 3'd2, 4'b1111, 32'h01234567, 0, 0, 0, 32'h0,        2'b10, 2, 3, 32'hDEADBEEF, 1'b0};
`else
        vecs[1] = '{1'b1, 32'h1c000002, 2'd0, 3'd0, 4'b0100, 32'h5A5A5A5A, 0, 1, 0, 32'h0,        2'b00, 4, 5, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h1c000008, 2'd2, 3'd2, 4'b1111, 32'h01234567, 0, 0, 0, 32'h0,        2'b10, 3, 4, 32'hDEADBEEF, 1'b1};
`endif
        vecs[3] = '{1'b0, 32'h1c000100, 2'd2, 3'd2, 4'b0000, 32'h0,        0, 0, 0, 32'h12345678, 2'b10, 3, 4, 32'h12345678, 1'b1};
`ifdef WR_EARLY_ACK_EN
        vecs[4] = '{1'b1, 32'h1c000010, 2'd1, 3'd1, 4'b0011, 32'hA5A5A5A5, 2, 0, 1, 32'h0,        2'b00, 4, 6, 32'h12345678, 1'b0};
        vecs[5] = '{1'b1, 32'h1c000020, 2'd2, 3'd2, 4'b1111, 32'hC0FFEE00, 0, 0, 5, 32'h0,        2'b00, 2, 8, 32'h12345678, 1'b0};
`else
        vecs[4] = '{1'b1, 32'h1c000010, 2'd1, 3'd1, 4'b0011, 32'hA5A5A5A5, 2, 0, 1, 32'h0,        2'b00, 6, 7, 32'h12345678, 1'b0};
        vecs[5] = '{1'b1, 32'h1c000020, 2'd2, 3'd2, 4'b1111, 32'hC0FFEE00, 0, 0, 5, 32'h0,        2'b00, 8, 9, 32'h12345678, 1'b0};
`endif

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_we    = 1'b0;
        bus.req_size  = '0;
        bus.req_wstrb = '0;
        bus.req_wdata = '0;
        clearSlave();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset addr_ok/data_ok", {30'd0, bus.req_addr_ok, bus.req_data_ok}, 32'h2);
        checkOutput("reset valids/readies",
                    {27'd0, bus.m_arvalid, bus.m_awvalid, bus.m_wvalid, bus.m_rready, bus.m_bready}, 32'h0);
        checkOutput("reset rdata", bus.req_rdata, 32'h0);
        checkOutput("reset resp_err", 32'(bus.resp_err), 32'h0);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

        // Back-to-back read then write with req_valid held high, zero-wait slave
`ifdef WR_EARLY_ACK_EN
        exp_addr_ok = 8'b1001_0001;
        exp_data_ok = 8'b0100_1000;
`else
        exp_addr_ok = 8'b0001_0001;
        exp_data_ok = 8'b1000_1000;
`endif
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h1c000040;
        bus.req_size  = 2'd2;
        bus.m_arready = 1'b1;
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        bus.m_rvalid  = 1'b1;
        bus.m_rlast   = 1'b1;
        bus.m_rdata   = 32'hCAFEF00D;
        bus.m_bvalid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput($sformatf("b2b addr_ok k%0d", k), 32'(bus.req_addr_ok), 32'(exp_addr_ok[k]));
            checkOutput($sformatf("b2b data_ok k%0d", k), 32'(bus.req_data_ok), 32'(exp_data_ok[k]));
            if (k == 1) begin
                checkOutput("b2b arvalid/arid", {27'd0, bus.m_arvalid, bus.m_arid}, 32'h10);
                bus.req_we    = 1'b1;
                bus.req_addr  = 32'h1c000044;
                bus.req_wstrb = 4'b1111;
                bus.req_wdata = 32'h11112222;
            end
            if (k == 3) checkOutput("b2b read rdata", bus.req_rdata, 32'hCAFEF00D);
            if (k == 5) checkOutput("b2b awvalid/wvalid/awid", {26'd0, bus.m_awvalid, bus.m_wvalid, bus.m_awid}, 32'h31);
            if (k == 7) bus.req_valid = 1'b0;
        end
        clearSlave();
        @(negedge clk);
        checkOutput("b2b final addr_ok", 32'(bus.req_addr_ok), 32'd1);

        // Reset asserted while waiting in RD_DATA
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h1c000080;
        bus.m_arready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checkOutput("rst arvalid", 32'(bus.m_arvalid), 32'd1);
        @(negedge clk);
        checkOutput("rst rready before reset", 32'(bus.m_rready), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst after: addr_ok/data_ok/rready/arvalid",
                    {28'd0, bus.req_addr_ok, bus.req_data_ok, bus.m_rready, bus.m_arvalid}, 32'h8);
        checkOutput("rst after: rdata", bus.req_rdata, 32'h0);
        bus.m_rvalid = 1'b1;
        bus.m_rlast  = 1'b1;
        bus.m_rdata  = 32'h00000BAD;
        begin
            int pulses = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (bus.req_data_ok) pulses++;
            end
            checkOutput("rst no data_ok pulse", 32'(pulses), 32'd0);
        end
        clearSlave();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
